itch_message_framer: RTL and testbench

- Parametrised successor to the ITCH message-type decoder: accepts a beat-aligned stream of length-prefixed ITCH messages (DATA_W bits per beat) over a valid/ready handshake.
- Extracts length and type, tracks message boundaries across multiple beats, and classifies the type against a configurable type table (NUM_TYPES channels).
- Forwards known messages with SOP/EOP framing and a one-hot start vector to the per-type field parsers.
- Drops unknown or malformed messages, reporting error pulses and saturating counters.

---
 rtl/itch_message_framer.sv | 165 ++++++++++++++++
 tb/tb_itch_message_framer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/itch_message_framer.sv
// Length-prefixed ITCH message framer: classifies the header type, frames the message with SOP/EOP, drops bad ones.
// One output register stage (1-cycle latency); in_ready = !out_valid || out_ready, outputs held while stalled.
module itch_message_framer #(
  parameter int                       DATA_W     = 64,
  parameter int                       NUM_TYPES  = 5,
  parameter logic [NUM_TYPES*8-1:0]   TYPE_CODES = {8'h44, 8'h43, 8'h45, 8'h46, 8'h41},
  parameter int                       MAX_LEN    = 64,
  parameter int                       CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [NUM_TYPES-1:0] out_start,
  output logic [7:0]           out_type,
  output logic [15:0]          out_length,
  output logic                 err_unknown,
  output logic                 err_length,
  output logic [CNT_W-1:0]     msg_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int BYTES = DATA_W / 8;

  typedef enum logic [1:0] {HDR, BODY, DROP} state_t;

  state_t                 state, nextState;
  logic [16:0]            remaining, nextRemaining;
  logic                   accept;
  logic [15:0]            hdrLen;
  logic [7:0]             hdrType;
  logic [16:0]            hdrBeats;
  logic                   lenBad;
  logic                   typeHit;
  logic [NUM_TYPES-1:0]   typeOneHot;
  logic                   load, loadSop, loadEop;
  logic [NUM_TYPES-1:0]   loadStart;
  logic                   setUnknown, setLength;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Length is big-endian in bytes 0..1 and excludes the 2-byte length field itself.
  assign hdrLen   = {in_data[7:0], in_data[15:8]};
  assign hdrType  = in_data[23:16];
  assign hdrBeats = ({1'b0, hdrLen} + 17'd2 + 17'(BYTES - 1)) / 17'(BYTES);
  assign lenBad   = (hdrLen == 16'd0) || ({1'b0, hdrLen} > 17'(MAX_LEN));

  // Scan from the top so the lowest matching channel is the one left standing.
  always_comb begin
    typeHit    = 1'b0;
    typeOneHot = '0;
    for (int i = NUM_TYPES - 1; i >= 0; i--) begin
      if (TYPE_CODES[8*i +: 8] == hdrType) begin
        typeHit       = 1'b1;
        typeOneHot    = '0;
        typeOneHot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    nextState     = state;
    nextRemaining = remaining;
    load          = 1'b0;
    loadSop       = 1'b0;
    loadEop       = 1'b0;
    loadStart     = '0;
    setUnknown    = 1'b0;
    setLength     = 1'b0;
    if (accept) begin
      unique case (state)
        HDR: begin
          if (lenBad) begin
            setLength = 1'b1;
          end else if (!typeHit) begin
            setUnknown = 1'b1;
            if (hdrBeats > 17'd1) begin
              nextState     = DROP;
              nextRemaining = hdrBeats - 17'd1;
            end
          end else begin
            load      = 1'b1;
            loadSop   = 1'b1;
            loadStart = typeOneHot;
            if (hdrBeats == 17'd1) begin
              loadEop = 1'b1;
            end else begin
              nextState     = BODY;
              nextRemaining = hdrBeats - 17'd1;
            end
          end
        end
        BODY: begin
          load          = 1'b1;
          nextRemaining = remaining - 17'd1;
          if (remaining == 17'd1) begin
            loadEop   = 1'b1;
            nextState = HDR;
          end
        end
        DROP: begin
          nextRemaining = remaining - 17'd1;
          if (remaining == 17'd1) nextState = HDR;
        end
        default: nextState = HDR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HDR;
      remaining <= '0;
    end else begin
      state     <= nextState;
      remaining <= nextRemaining;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_start   <= '0;
      out_type    <= '0;
      out_length  <= '0;
      err_unknown <= 1'b0;
      err_length  <= 1'b0;
      msg_cnt     <= '0;
      drop_cnt    <= '0;
    end else begin
      err_unknown <= setUnknown;
      err_length  <= setLength;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
        out_sop   <= loadSop;
        out_eop   <= loadEop;
        out_start <= loadStart;
        if (loadSop) begin
          out_type   <= hdrType;
          out_length <= hdrLen;
        end
      end else if (out_ready) begin
        // Type/length stay latched; only the per-beat framing flags are cleared.
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
        out_start <= '0;
      end
      if (load && loadEop && (msg_cnt != '1)) msg_cnt <= msg_cnt + 1'b1;
      if ((setUnknown || setLength) && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_itch_message_framer.sv
// Scoreboard bench for itch_message_framer: directed messages push expected beats, a negedge monitor pops and compares.
module tb_itch_message_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic [4:0]  out_start;
  logic [7:0]  out_type;
  logic [15:0] out_length;
  logic        err_unknown;
  logic        err_length;
  logic [15:0] msg_cnt;
  logic [15:0] drop_cnt;

  itch_message_framer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_start(out_start),
    .out_type(out_type), .out_length(out_length),
    .err_unknown(err_unknown), .err_length(err_length),
    .msg_cnt(msg_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [4:0]  start;
    logic [7:0]  typ;
    logic [15:0] len;
  } expBeat_t;

  expBeat_t expQ[$];
  int       sopCycles[$];
  int       assertions = 0;
  int       failures   = 0;
  int       cycle      = 0;
  int       unkSeen    = 0;
  int       lenSeen    = 0;
  int       expMsg     = 0;
  int       expDrop    = 0;
  int       expUnk     = 0;
  int       expLen     = 0;

  function automatic logic [4:0] chanOf(input logic [7:0] typ);
    case (typ)
      8'h41:   return 5'b00001;
      8'h46:   return 5'b00010;
      8'h45:   return 5'b00100;
      8'h43:   return 5'b01000;
      8'h44:   return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [63:0] hdrBeat(input logic [15:0] len, input logic [7:0] typ, input logic [7:0] tag);
    return {32'hDEADBEEF, tag, typ, len[7:0], len[15:8]};
  endfunction

  function automatic logic [63:0] bodyBeat(input logic [7:0] tag, input int b);
    return {tag, 8'(b), 48'h0123_4567_89AB};
  endfunction

  // Monitor: a beat is transferred at the next rising edge when valid && ready at the falling edge.
  initial begin
    expBeat_t e;
    forever begin
      @(negedge clk);
      cycle++;
      if (err_unknown) unkSeen++;
      if (err_length)  lenSeen++;
      if (rst && out_valid && out_ready) begin
        assertions++;
        if (expQ.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: got data=%h sop=%b eop=%b start=%b, required no beat", out_data, out_sop, out_eop, out_start);
        end else begin
          e = expQ.pop_front();
          if (out_data !== e.data || out_sop !== e.sop || out_eop !== e.eop || out_start !== e.start ||
              out_type !== e.typ || out_length !== e.len) begin
            failures++;
            $display("FAIL out_beat: got data=%h sop=%b eop=%b start=%b type=%h len=%0d, required data=%h sop=%b eop=%b start=%b type=%h len=%0d",
                     out_data, out_sop, out_eop, out_start, out_type, out_length,
                     e.data, e.sop, e.eop, e.start, e.typ, e.len);
          end
          if (out_sop) sopCycles.push_back(cycle);
        end
      end
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    assertions++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic sendBeat(input logic [63:0] d);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
    end
    #1;
    assertions++;
    if (!done) begin
      failures++;
      $display("FAIL in_handshake_timeout: got in_ready=0 for 100 cycles, required 1");
    end
  endtask

  task automatic stall(input logic [63:0] prevD, input logic [63:0] nextD);
    in_data   = nextD;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      assertions++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== prevD || out_eop !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold: got in_ready=%b out_valid=%b data=%h eop=%b, required 0 1 %h 0",
                 in_ready, out_valid, out_data, out_eop, prevD);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
  endtask

  task automatic sendMsg(input logic [15:0] len, input logic [7:0] typ, input logic [7:0] tag, input int stallAfter);
    int          nb;
    logic [4:0]  ch;
    logic [63:0] d, prev;
    expBeat_t    e;
    ch   = chanOf(typ);
    prev = '0;
    if (len == 16'd0 || len > 16'd64) begin
      expLen++;
      expDrop++;
      sendBeat(hdrBeat(len, typ, tag));
      return;
    end
    nb = (int'(len) + 2 + 7) / 8;
    if (ch == 5'b0) begin
      expUnk++;
      expDrop++;
    end else begin
      expMsg++;
    end
    for (int b = 0; b < nb; b++) begin
      d = (b == 0) ? hdrBeat(len, typ, tag) : bodyBeat(tag, b);
      if (b == stallAfter) stall(prev, d);
      if (ch != 5'b0) begin
        e.data  = d;
        e.sop   = (b == 0);
        e.eop   = (b == nb - 1);
        e.start = (b == 0) ? ch : 5'b0;
        e.typ   = typ;
        e.len   = len;
        expQ.push_back(e);
      end
      sendBeat(d);
      prev = d;
    end
  endtask

  task automatic checkpoint(input string tag);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_msg_cnt"},  msg_cnt,  expMsg);
    check({tag, "_drop_cnt"}, drop_cnt, expDrop);
    check({tag, "_err_unknown_pulses"}, unkSeen, expUnk);
    check({tag, "_err_length_pulses"},  lenSeen, expLen);
    check({tag, "_pending_beats"}, expQ.size(), 0);
  endtask

  initial begin
    expBeat_t e;
    int       base;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {out_valid, out_sop, out_eop, out_start, out_type, out_length, err_unknown, err_length}, 0);
    check("reset_counters", {msg_cnt, drop_cnt}, 0);
    check("reset_in_ready", in_ready, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 5-beat 'A' message.
    sendMsg(16'd36, 8'h41, 8'h01, -1);
    checkpoint("msgA");

    // Single-beat 'D' immediately followed by 'F', no idle between.
    base = sopCycles.size();
    sendMsg(16'd5, 8'h44, 8'h02, -1);
    sendMsg(16'd10, 8'h46, 8'h03, -1);
    checkpoint("b2b");
    check("b2b_sop_gap", (sopCycles.size() >= base + 2) ? sopCycles[base+1] - sopCycles[base] : -1, 1);

    // Unknown type spanning 3 beats, then a normal header.
    sendMsg(16'd20, 8'h5A, 8'h04, -1);
    sendMsg(16'd6, 8'h43, 8'h05, -1);
    checkpoint("unknown");

    // Illegal lengths, then a normal 2-beat message.
    sendMsg(16'd0, 8'h41, 8'h06, -1);
    sendMsg(16'd100, 8'h41, 8'h07, -1);
    sendMsg(16'd14, 8'h41, 8'h08, -1);
    checkpoint("badlen");

    // Backpressure for 4 cycles mid-body.
    sendMsg(16'd36, 8'h46, 8'h09, 3);
    checkpoint("stall");

    // Reset while beat 3 of a 5-beat message is offered.
    e.typ = 8'h41; e.len = 16'd36;
    e.data = hdrBeat(16'd36, 8'h41, 8'h0A); e.sop = 1'b1; e.eop = 1'b0; e.start = 5'b00001;
    expQ.push_back(e);
    sendBeat(e.data);
    e.data = bodyBeat(8'h0A, 1); e.sop = 1'b0; e.start = 5'b0;
    expQ.push_back(e);
    sendBeat(e.data);
    in_data = bodyBeat(8'h0A, 2);
    @(negedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    expMsg   = 0;
    expDrop  = 0;
    repeat (2) begin
      @(negedge clk);
      check("inreset_outputs", {out_valid, out_data, out_sop, out_eop, out_start, out_type, out_length, err_unknown, err_length}, 0);
      check("inreset_counters", {msg_cnt, drop_cnt}, 0);
    end
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    sendMsg(16'd3, 8'h45, 8'h0B, -1);
    checkpoint("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
